// File: rtl/alu_arbiter.sv
// Two-port round-robin sequencer in front of a shared registered ALU.
// One operation in flight: IDLE (accept) -> EXEC (alu_ena) -> CAPT (capture) -> IDLE.

module alu_arbiter_rsp #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] data
);
  // data is sticky; valid is a single-cycle pulse following load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= load;
      if (load) data <= din;
    end
  end
endmodule

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic [1:0]        req0_op,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic [1:0]        req1_op,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              alu_ena,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);
  localparam int NPORT = 2;
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [1:0]        op;
  } req_t;

  req_t [NPORT-1:0]             req;
  logic [NPORT-1:0]             req_vld;
  logic [NPORT-1:0]             rsp_vld;
  logic [NPORT-1:0][DATA_W-1:0] rsp_dat;

  logic [1:0]       state;
  logic             last_grant, gnt_id, grant, accept;
  req_t             lat;
  logic [CNT_W-1:0] cnt;

  assign req[0]  = {req0_x, req0_y, req0_op};
  assign req[1]  = {req1_x, req1_y, req1_op};
  assign req_vld = {req1_valid, req0_valid};

  // On contention the port that did not win last time gets the slot
  always_comb begin
    grant = 1'b0;
    case (req_vld)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign accept     = (state == IDLE) && (|req_vld);
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      lat        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat        <= req[grant];
          gnt_id     <= grant;
          last_grant <= grant;
          state      <= EXEC;
        end
        EXEC:    state <= CAPT;
        CAPT: begin
          cnt   <= cnt + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_rsp
    localparam logic PID = 1'(p);
    alu_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
      .clk   (clk),
      .rst   (rst),
      .load  ((state == CAPT) && (gnt_id == PID)),
      .din   (alu_out),
      .valid (rsp_vld[p]),
      .data  (rsp_dat[p])
    );
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_data  = rsp_dat[0];
  assign rsp1_data  = rsp_dat[1];

  // Operands track the latch continuously so they are stable around alu_ena
  assign alu_ena  = (state == EXEC);
  assign alu_x    = lat.x;
  assign alu_y    = lat.y;
  assign alu_op   = lat.op;
  assign busy     = (state != IDLE);
  assign ops_done = cnt;
endmodule
